// File: rtl/seg7_scan_ctrl_if.sv
// Avalon-MM slave bus bundle for the seven-segment scan controller.
interface seg7_scan_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with dead-time gaps
// between digit slots and an Avalon-MM register file.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seg7_scan_ctrl_if.slave       bus,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_en
);

  localparam int N        = NUM_DIGITS;
  localparam int DW       = 4 * N;
  localparam int SHOW_LEN = CLK_DIV - BLANK_CYCLES;
  localparam int CW       = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [DW-1:0] data_q;
  logic          en_q;
  logic [N-1:0]  blank_q;
  state_e        state_q;
  logic [2:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic [6:0]    seg_q;
  logic [N-1:0]  den_q;

  logic          wr;
  logic [2:0]    idx_d;
  logic [3:0]    nib_d;
  logic [N-1:0]  den_d;
  logic [N-1:0]  den0;

  assign wr = bus.chipselect && !bus.write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      en_q    <= 1'b0;
      blank_q <= '0;
    end else if (wr) begin
      unique case (bus.address)
        2'd0: data_q  <= bus.writedata[DW-1:0];
        2'd1: en_q    <= bus.writedata[0];
        2'd2: blank_q <= bus.writedata[N-1:0];
        2'd3: ;
      endcase
    end
  end

  assign idx_d = (idx_q == 3'(N - 1)) ? 3'd0 : idx_q + 3'd1;
  assign nib_d = 4'(data_q >> {idx_d, 2'b00});
  assign den_d = (N'(1) << idx_d) & ~blank_q;
  assign den0  = N'(1) & ~blank_q;

  // Segment data is sampled only on slot entry so a lit digit never tears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= '0;
      den_q   <= '0;
    end else if (!en_q) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= '0;
      den_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= SHOW;
          idx_q   <= '0;
          cnt_q   <= '0;
          seg_q   <= hex7(data_q[3:0]);
          den_q   <= den0;
        end
        SHOW: begin
          if (cnt_q == CW'(SHOW_LEN - 1)) begin
            state_q <= GAP;
            cnt_q   <= '0;
            den_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            idx_q   <= idx_d;
            seg_q   <= hex7(nib_d);
            den_q   <= den_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          den_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      2'd0: bus.readdata = 32'(data_q);
      2'd1: bus.readdata = {31'b0, en_q};
      2'd2: bus.readdata = 32'(blank_q);
      2'd3: bus.readdata = {22'b0, state_q, 5'b0, idx_q};
    endcase
  end

  assign seg      = ACTIVE_LOW ? ~seg_q : seg_q;
  assign digit_en = ACTIVE_LOW ? ~den_q : den_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed testbench for seg7_scan_ctrl: readback, scan order,
// tear-free updates, blanking, disable and async reset.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int CD = 10;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] seg;
  logic [3:0] digit_en;

  int checks = 0;
  int errors = 0;

  logic [6:0] hexs [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .CLK_DIV     (CD),
    .BLANK_CYCLES(BC),
    .ACTIVE_LOW  (1'b0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .seg     (seg),
    .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    checks++;
    if (seg !== 7'h00 || digit_en !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pins seg=%h den=%b exp 00/0000", seg, digit_en);
    end
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_read a=%0d got=%h exp=0", a, rd);
      end
    end
  endtask

  task automatic test_readback();
    logic [31:0] rd;
    bus_write(2'd0, 32'h1234);
    bus_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0000_1234) begin
      errors++;
      $display("FAIL data_rd got=%h exp=00001234", rd);
    end
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL data_trunc got=%h exp=0000ffff", rd);
    end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL status_ro got=%h exp=0", rd);
    end
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL ctrl_rd got=%h exp=1", rd);
    end
    bus_write(2'd1, 32'h0);
  endtask

  task automatic test_scan();
    int slot, pos, dig;
    logic [6:0] es;
    logic [3:0] ed;
    bus_write(2'd0, 32'h1234);
    bus_write(2'd1, 32'h1);
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
      es = 7'h00;
      ed = 4'b0000;
      if (c > 0) begin
        slot = (c - 1) / CD;
        pos  = (c - 1) % CD;
        dig  = slot % N;
        es = hexs[(32'h1234 >> (4 * dig)) & 15];
        ed = (pos < CD - BC) ? 4'(1 << dig) : 4'b0000;
      end
      checks++;
      if (seg !== es || digit_en !== ed) begin
        errors++;
        $display("FAIL scan c=%0d seg=%h den=%b exp %h/%b",
                 c, seg, digit_en, es, ed);
      end
    end
    bus_write(2'd1, 32'h0);
  endtask

  task automatic test_tear_free();
    int slot, pos, dig;
    logic [31:0] w;
    logic [6:0]  es;
    logic [3:0]  ed;
    bus_write(2'd0, 32'h1234);
    bus_write(2'd1, 32'h1);
    for (int c = 0; c <= 41; c++) begin
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      es = 7'h00;
      ed = 4'b0000;
      if (c > 0) begin
        slot = (c - 1) / CD;
        pos  = (c - 1) % CD;
        dig  = slot % N;
        w  = (slot >= 1) ? 32'hABCD : 32'h1234;
        es = hexs[(w >> (4 * dig)) & 15];
        ed = (pos < CD - BC) ? 4'(1 << dig) : 4'b0000;
      end
      checks++;
      if (seg !== es || digit_en !== ed) begin
        errors++;
        $display("FAIL tear c=%0d seg=%h den=%b exp %h/%b",
                 c, seg, digit_en, es, ed);
      end
      if (c == 3) begin
        bus.address    = 2'd0;
        bus.writedata  = 32'hABCD;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
      end
    end
    bus_write(2'd1, 32'h0);
  endtask

  task automatic test_blanking();
    int slot, pos, dig;
    logic [6:0]  es;
    logic [3:0]  ed;
    logic [31:0] est;
    bus_write(2'd0, 32'h1234);
    bus_write(2'd2, 32'h5);
    bus_write(2'd1, 32'h1);
    bus.address = 2'd3;
    for (int c = 0; c <= 41; c++) begin
      @(negedge clk);
      es  = 7'h00;
      ed  = 4'b0000;
      est = 32'h0;
      if (c > 0) begin
        slot = (c - 1) / CD;
        pos  = (c - 1) % CD;
        dig  = slot % N;
        es = hexs[(32'h1234 >> (4 * dig)) & 15];
        ed = (pos < CD - BC) ? (4'(1 << dig) & 4'b1010) : 4'b0000;
        est = ((pos < CD - BC) ? 32'h100 : 32'h200) | 32'(dig);
      end
      checks++;
      if (seg !== es || digit_en !== ed || bus.readdata !== est) begin
        errors++;
        $display("FAIL blank c=%0d seg=%h den=%b st=%h exp %h/%b/%h",
                 c, seg, digit_en, bus.readdata, es, ed, est);
      end
    end
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'h0);
  endtask

  task automatic test_disable();
    int slot, pos, dig;
    logic [6:0] es;
    logic [3:0] ed;
    bus_write(2'd0, 32'h1234);
    bus_write(2'd1, 32'h1);
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      es = 7'h00;
      ed = 4'b0000;
      if (c > 0) begin
        slot = (c - 1) / CD;
        pos  = (c - 1) % CD;
        dig  = slot % N;
        es = hexs[(32'h1234 >> (4 * dig)) & 15];
        ed = (pos < CD - BC) ? 4'(1 << dig) : 4'b0000;
      end
      checks++;
      if (seg !== es || digit_en !== ed) begin
        errors++;
        $display("FAIL dis_run c=%0d seg=%h den=%b exp %h/%b",
                 c, seg, digit_en, es, ed);
      end
      if (c == 23) begin
        bus.address    = 2'd1;
        bus.writedata  = 32'h0;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
      end
    end
    @(negedge clk);
    bus.address = 2'd3;
    #1;
    checks++;
    if (seg !== 7'h00 || digit_en !== 4'b0000 || bus.readdata !== 32'h0) begin
      errors++;
      $display("FAIL dis_off seg=%h den=%b st=%h exp 00/0000/0",
               seg, digit_en, bus.readdata);
    end
    bus_write(2'd1, 32'h1);
    @(negedge clk);
    checks++;
    if (digit_en !== 4'b0000) begin
      errors++;
      $display("FAIL reen_wait den=%b exp 0000", digit_en);
    end
    @(negedge clk);
    checks++;
    if (seg !== 7'h66 || digit_en !== 4'b0001) begin
      errors++;
      $display("FAIL reen_lit seg=%h den=%b exp 66/0001", seg, digit_en);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    bus_write(2'd1, 32'h0);
    bus_write(2'd0, 32'h1234);
    bus_write(2'd2, 32'h8);
    bus_write(2'd1, 32'h1);
    repeat (4) @(negedge clk);
    checks++;
    if (digit_en !== 4'b0001) begin
      errors++;
      $display("FAIL ares_pre den=%b exp 0001", digit_en);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (seg !== 7'h00 || digit_en !== 4'b0000) begin
      errors++;
      $display("FAIL ares_pins seg=%h den=%b exp 00/0000", seg, digit_en);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL ares_read a=%0d got=%h exp=0", a, rd);
      end
    end
  endtask

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_readback();
    test_scan();
    test_tear_free();
    test_blanking();
    test_disable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
